imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into words,
// writes them sequentially from address 0 and holds the core in reset until loaded.
module imem_loader #(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ADDR-1:0] len_words,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            WE,
  output logic [DATA-1:0] WD,
  output logic [ADDR-1:0] PC,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cpu_rst_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR-1:0] DEPTH_L = ADDR'(MEM_DEPTH);
  localparam logic [ADDR-1:0] ZERO_L  = '0;
  localparam logic [ADDR-1:0] ONE_L   = ADDR'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_byte_cnt;
  logic [ADDR-1:0] r_word_idx;
  logic [ADDR-1:0] r_len;
  logic [DATA-1:0] r_word;
  logic [DATA-1:0] w_word_asm;
  logic            w_start_seen;
  logic            w_len_bad;
  logic            w_len_zero;
  logic            w_accept;
  logic            w_last_word;

  assign w_start_seen = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_len_bad    = (len_words > DEPTH_L);
  assign w_len_zero   = (len_words == ZERO_L);
  assign w_accept     = (r_state == S_LOAD) && in_valid;
  assign w_last_word  = ((r_word_idx + ONE_L) == r_len);

  // Word under assembly with the current byte merged into its lane
  always_comb begin
    w_word_asm = r_word;
    w_word_asm[{r_byte_cnt, 3'b000} +: 8] = in_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (w_len_bad) begin
            w_state_nxt = S_IDLE;
          end else if (w_len_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LOAD: begin
        if (in_valid && (r_byte_cnt == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_WRITE: begin
        if (w_last_word) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track the FSM glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      WE        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      in_ready  <= (w_state_nxt == S_LOAD);
      WE        <= (w_state_nxt == S_WRITE);
      busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_WRITE);
      done      <= (w_state_nxt == S_DONE);
      cpu_rst_n <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: length latch, byte assembly, write word/address and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_word_idx <= '0;
      r_len      <= '0;
      r_word     <= '0;
      WD         <= '0;
      PC         <= '0;
      err        <= 1'b0;
    end else begin
      if (w_start_seen) begin
        if (w_len_bad) begin
          err <= 1'b1;
        end else begin
          err        <= 1'b0;
          r_byte_cnt <= 2'd0;
          r_word_idx <= '0;
          r_len      <= len_words;
        end
      end else if (w_accept) begin
        r_word     <= w_word_asm;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          WD <= w_word_asm;
          PC <= r_word_idx << 2;
        end else begin
          WD <= WD;
        end
      end else if ((r_state == S_WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + ONE_L;
      end else begin
        r_word_idx <= r_word_idx;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: expected writes come from the
// word list itself (byte k of word i at PC 4*i), gaps are random.
module tb_imem_loader;

  localparam int DATA      = 32;
  localparam int ADDR      = 32;
  localparam int MEM_DEPTH = 256;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [ADDR-1:0] len_words;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            WE;
  logic [DATA-1:0] WD;
  logic [ADDR-1:0] PC;
  logic            busy;
  logic            done;
  logic            err;
  logic            cpu_rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int gap_q[$];

  imem_loader #(.DATA(DATA), .ADDR(ADDR), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .WE(WE), .WD(WD), .PC(PC), .busy(busy), .done(done), .err(err),
    .cpu_rst_n(cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses: WE is seen at the edge that ends its cycle
  always @(posedge clk) begin
    if (WE === 1'b1) we_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".WE"}, WE, 0);
    check_eq({tag, ".WD"}, WD, 0);
    check_eq({tag, ".PC"}, PC, 0);
    check_eq({tag, ".in_ready"}, in_ready, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".err"}, err, 0);
    check_eq({tag, ".cpu_rst_n"}, cpu_rst_n, 0);
  endtask

  task automatic do_start(input logic [ADDR-1:0] n);
    start     = 1'b1;
    len_words = n;
    @(negedge clk);
    start     = 1'b0;
    len_words = $urandom;
  endtask

  task automatic run_load(input string tag, input int n, input logic [31:0] words[$]);
    int base;
    int g;
    logic [31:0] w;
    base = we_cnt;
    do_start(n);
    check_eq({tag, ".busy_after_start"}, busy, 1);
    check_eq({tag, ".cpu_rst_n_after_start"}, cpu_rst_n, 0);
    check_eq({tag, ".err_after_start"}, err, 0);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        g = (gap_q.size() > 0) ? gap_q.pop_front() : int'($urandom_range(0, 2));
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          @(negedge clk);
          check_eq({tag, ".stall_no_we"}, WE, 0);
        end
        check_eq({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = w[8*k +: 8];
        @(negedge clk);
      end
      in_valid = 1'b0;
      check_eq({tag, ".WE"}, WE, 1);
      check_eq({tag, ".PC"}, PC, 64'(i * 4));
      check_eq({tag, ".WD"}, WD, w);
      check_eq({tag, ".in_ready_in_write"}, in_ready, 0);
      @(negedge clk);
      check_eq({tag, ".WE_one_cycle"}, WE, 0);
    end
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".cpu_rst_n"}, cpu_rst_n, 1);
    check_eq({tag, ".busy_end"}, busy, 0);
    check_eq({tag, ".we_count"}, we_cnt - base, n);
    check_eq({tag, ".WD_hold"}, WD, words[n-1]);
    check_eq({tag, ".PC_hold"}, PC, 64'((n - 1) * 4));
  endtask

  initial begin
    logic [31:0] q[$];
    int base;
    rst_n     = 1'b1;
    start     = 1'b0;
    len_words = '0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    q = {32'h00500013, 32'h00A000B3};
    run_load("two_words", 2, q);

    gap_q = {0, 2, 0, 1};
    q = {32'h44332211};
    run_load("gapped", 1, q);

    base = we_cnt;
    do_start(ADDR'(MEM_DEPTH + 1));
    check_eq("reject.err", err, 1);
    check_eq("reject.cpu_rst_n", cpu_rst_n, 0);
    check_eq("reject.done", done, 0);
    check_eq("reject.busy", busy, 0);
    repeat (3) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check_eq("reject.in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check_eq("reject.no_we", we_cnt - base, 0);
    check_eq("reject.err_sticky", err, 1);

    base = we_cnt;
    do_start('0);
    check_eq("zero.done", done, 1);
    check_eq("zero.cpu_rst_n", cpu_rst_n, 1);
    check_eq("zero.err_cleared", err, 0);
    repeat (2) @(negedge clk);
    check_eq("zero.no_we", we_cnt - base, 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < n; i++) q.push_back($urandom);
      run_load("random", n, q);
    end

    q = {};
    for (int i = 0; i < MEM_DEPTH; i++) q.push_back($urandom);
    run_load("full", MEM_DEPTH, q);
    check_eq("full.last_pc", PC, 64'h3FC);

    q = {$urandom, $urandom, $urandom};
    run_load("reload", 3, q);

    do_start(ADDR'(MEM_DEPTH + 5));
    check_eq("done_reject.err", err, 1);
    check_eq("done_reject.cpu_rst_n", cpu_rst_n, 0);
    check_eq("done_reject.done", done, 0);

    base = we_cnt;
    do_start(2);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("abort.first_word_written", we_cnt - base, 1);
    base = we_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    in_valid = 1'b1;
    in_data  = $urandom;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort.no_partial_we", we_cnt - base, 0);
    check_eq("abort.busy", busy, 0);
    check_eq("abort.cpu_rst_n", cpu_rst_n, 0);

    q = {$urandom};
    run_load("after_abort", 1, q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
